// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared types and constants for the MIPS multiply/divide unit.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam int WORD_W  = 32;
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } md_state_t;

  function automatic logic [WORD_W-1:0] negw(input logic [WORD_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [WORD_W-1:0] abs_w(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? negw(v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_div_step.sv
`default_nettype none
// ============================================================================
// div_restoring_step : one combinational restoring-division step on magnitudes.
// Revision : 1.0
// ============================================================================
module div_restoring_step
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] rem_i,
  input  logic [WORD_W-1:0] quo_i,
  input  logic [WORD_W-1:0] div_i,
  output logic [WORD_W-1:0] rem_o,
  output logic [WORD_W-1:0] quo_o
);

  logic [WORD_W:0] shifted;
  logic [WORD_W:0] trial;

  assign shifted = {rem_i, quo_i[WORD_W-1]};
  assign trial   = shifted - {1'b0, div_i};

  // Partial remainder stays below the divisor, so a set borrow bit means "restore".
  always_comb begin
    if (!trial[WORD_W]) begin
      rem_o = trial[WORD_W-1:0];
      quo_o = {quo_i[WORD_W-2:0], 1'b1};
    end else begin
      rem_o = shifted[WORD_W-1:0];
      quo_o = {quo_i[WORD_W-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : multicycle signed 32-bit multiply/divide feeding MIPS HI/LO.
// Option   : define MULT_DIV_ZERO_TRAP_EN to trap divide-by-zero on DivZero.
// Revision : 1.0
// ============================================================================
module mult_div_unit
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              MultOp,
  input  logic              DivOp,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic              Busy,
  output logic              Done,
  output logic              DivZero,
  output logic [WORD_W-1:0] ResultHI,
  output logic [WORD_W-1:0] ResultLO
);

  md_state_t           state_q;
  logic [5:0]          cnt_q;
  logic [2*WORD_W:0]   acc_q;
  logic [WORD_W-1:0]   opnd_q;
  logic                quo_neg_q;
  logic                rem_neg_q;
  logic                dz_q;
  logic                op_div_q;
  logic                busy_q;
  logic                done_q;
  logic [WORD_W-1:0]   hi_q;
  logic [WORD_W-1:0]   lo_q;

  logic [WORD_W:0]     booth_sum_d;
  logic [2*WORD_W:0]   booth_acc_d;
  logic [WORD_W-1:0]   div_rem_d;
  logic [WORD_W-1:0]   div_quo_d;
  logic [WORD_W-1:0]   res_hi_d;
  logic [WORD_W-1:0]   res_lo_d;
  logic                last_step;

  // Accumulator layout: {hi[64:33], lo[32:1], booth_prev[0]}; the add is done
  // one bit wider so a 0x80000000 multiplicand cannot overflow the partial sum.
  always_comb begin
    booth_sum_d = {acc_q[2*WORD_W], acc_q[2*WORD_W:WORD_W+1]};
    case (acc_q[1:0])
      2'b01:   booth_sum_d = booth_sum_d + {opnd_q[WORD_W-1], opnd_q};
      2'b10:   booth_sum_d = booth_sum_d - {opnd_q[WORD_W-1], opnd_q};
      default: booth_sum_d = booth_sum_d;
    endcase
    booth_acc_d = {booth_sum_d, acc_q[WORD_W:1]};
  end

  div_restoring_step u_div_step (
    .rem_i (acc_q[2*WORD_W-1:WORD_W]),
    .quo_i (acc_q[WORD_W-1:0]),
    .div_i (opnd_q),
    .rem_o (div_rem_d),
    .quo_o (div_quo_d)
  );

  // A zero divisor keeps the raw all-ones quotient; the remainder still
  // takes the dividend's sign, giving back the original dividend.
  always_comb begin
    if (op_div_q) begin
      res_lo_d = (quo_neg_q && !dz_q) ? negw(acc_q[WORD_W-1:0]) : acc_q[WORD_W-1:0];
      res_hi_d = rem_neg_q ? negw(acc_q[2*WORD_W-1:WORD_W]) : acc_q[2*WORD_W-1:WORD_W];
    end else begin
      res_lo_d = acc_q[WORD_W:1];
      res_hi_d = acc_q[2*WORD_W:WORD_W+1];
    end
  end

  assign last_step = (cnt_q == 6'(MD_ITER - 1));

`ifdef MULT_DIV_ZERO_TRAP_EN
  logic divzero_q;
  assign DivZero = divzero_q;
`else
  assign DivZero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      op_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULT_DIV_ZERO_TRAP_EN
      divzero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULT_DIV_ZERO_TRAP_EN
      divzero_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (MultOp) begin
            acc_q    <= {{WORD_W{1'b0}}, B, 1'b0};
            opnd_q   <= A;
            op_div_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= MULT;
          end else if (DivOp) begin
            acc_q     <= {1'b0, {WORD_W{1'b0}}, abs_w(A)};
            opnd_q    <= abs_w(B);
            quo_neg_q <= A[WORD_W-1] ^ B[WORD_W-1];
            rem_neg_q <= A[WORD_W-1];
            dz_q      <= (B == '0);
            op_div_q  <= 1'b1;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
`ifdef MULT_DIV_ZERO_TRAP_EN
            state_q   <= (B == '0) ? FINISH : DIV;
`else
            state_q   <= DIV;
`endif
          end
        end
        MULT: begin
          acc_q <= booth_acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (last_step) state_q <= FINISH;
        end
        DIV: begin
          acc_q <= {1'b0, div_rem_d, div_quo_d};
          cnt_q <= cnt_q + 6'd1;
          if (last_step) state_q <= FINISH;
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          cnt_q   <= '0;
`ifdef MULT_DIV_ZERO_TRAP_EN
          if (op_div_q && dz_q) begin
            divzero_q <= 1'b1;
          end else begin
            hi_q <= res_hi_d;
            lo_q <= res_lo_d;
          end
`else
          hi_q <= res_hi_d;
          lo_q <= res_lo_d;
`endif
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign ResultHI = hi_q;
  assign ResultLO = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : randomized self-checking bench for mult_div_unit.
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MultOp, DivOp;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero;
  logic [31:0] ResultHI, ResultLO;

  int          checks = 0;
  int          errors = 0;
  int          obs_lat, obs_busy;
  logic [31:0] obs_hi, obs_lo;
  logic        obs_dz;
  logic [31:0] exp_hi, exp_lo;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .MultOp(MultOp), .DivOp(DivOp), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero),
    .ResultHI(ResultHI), .ResultLO(ResultLO)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  // Returns {remainder, quotient}; SV division truncates toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request and wait (bounded) for Done; operands are scrambled after
  // the start edge so latching is exercised on every operation.
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MultOp = m; DivOp = d; A = a; B = b;
    @(negedge clk);
    MultOp = 1'b0; DivOp = 1'b0; A = $urandom; B = $urandom;
    obs_busy = Busy ? 1 : 0;
    obs_lat  = 0;
    while (!Done && obs_lat < 100) begin
      @(negedge clk);
      obs_lat++;
      if (Busy) obs_busy++;
    end
    obs_hi = ResultHI; obs_lo = ResultLO; obs_dz = DivZero;
  endtask

  task automatic test_reset();
    reset = 1'b1; MultOp = 1'b0; DivOp = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    checks++; if ({Busy, Done, DivZero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {Busy, Done, DivZero}); end
    checks++; if ({ResultHI, ResultLO} !== 64'd0) begin errors++; $display("FAIL reset_results: got %h expected 0", {ResultHI, ResultLO}); end
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_mult();
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    checks++; if (obs_lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", obs_lat); end
    checks++; if (obs_busy !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", obs_busy); end
    checks++; if ({obs_hi, obs_lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_7x-3: got %h expected ffffffffffffffeb", {obs_hi, obs_lo}); end
    checks++; if (obs_dz !== 1'b0) begin errors++; $display("FAIL mult_divzero: got %b expected 0", obs_dz); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
  endtask

  task automatic test_div();
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    checks++; if (obs_lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", obs_lat); end
    checks++; if ({obs_hi, obs_lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_-7/2: got %h expected fffffffffffffffd", {obs_hi, obs_lo}); end
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++; if ({obs_hi, obs_lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_min/-1: got %h expected 0000000080000000", {obs_hi, obs_lo}); end
    exp_hi = 32'd0; exp_lo = 32'h8000_0000;
  endtask

  task automatic test_div_zero();
    do_op(1'b0, 1'b1, 32'd5, 32'd0);
`ifdef MULT_DIV_ZERO_TRAP_EN
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL divzero_latency: got %0d expected 1", obs_lat); end
    checks++; if (obs_dz !== 1'b1) begin errors++; $display("FAIL divzero_flag: got %b expected 1", obs_dz); end
    checks++; if ({obs_hi, obs_lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL divzero_results_held: got %h expected %h", {obs_hi, obs_lo}, {exp_hi, exp_lo}); end
`else
    checks++; if (obs_lat !== 33) begin errors++; $display("FAIL divzero_latency: got %0d expected 33", obs_lat); end
    checks++; if (obs_dz !== 1'b0) begin errors++; $display("FAIL divzero_flag: got %b expected 0", obs_dz); end
    checks++; if ({obs_hi, obs_lo} !== 64'h0000_0005_FFFF_FFFF) begin errors++; $display("FAIL divzero_results: got %h expected 00000005ffffffff", {obs_hi, obs_lo}); end
    exp_hi = 32'd5; exp_lo = 32'hFFFF_FFFF;
`endif
  endtask

  task automatic test_overlap();
    logic [31:0] a, b;
    logic [63:0] e;
    int lat;
    a = $urandom; b = $urandom; e = ref_mul(a, b);
    @(negedge clk); MultOp = 1'b1; A = a; B = b;
    @(negedge clk); MultOp = 1'b0;
    lat = 0;
    while (!Done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 9)  begin DivOp = 1'b1; A = $urandom; B = $urandom; end
      if (lat == 10) DivOp = 1'b0;
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL overlap_latency: got %0d expected 33", lat); end
    checks++; if ({ResultHI, ResultLO} !== e) begin errors++; $display("FAIL overlap_result: got %h expected %h", {ResultHI, ResultLO}, e); end
    // Both requests together: multiply wins.
    a = 32'hFFFF_FF85; b = 32'h0001_2345; e = ref_mul(a, b);
    do_op(1'b1, 1'b1, a, b);
    checks++; if ({obs_hi, obs_lo} !== e) begin errors++; $display("FAIL both_requests: got %h expected %h", {obs_hi, obs_lo}, e); end
    {exp_hi, exp_lo} = e;
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk); DivOp = 1'b1; A = 32'h1234_5678; B = 32'd3;
    @(negedge clk); DivOp = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", Busy); end
    checks++; if ({ResultHI, ResultLO} !== 64'd0) begin errors++; $display("FAIL midreset_results: got %h expected 0", {ResultHI, ResultLO}); end
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      if (Done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_done: got %0d pulses expected 0", seen); end
    do_op(1'b1, 1'b0, 32'd3, 32'd4);
    checks++; if ({obs_hi, obs_lo} !== 64'd12 || obs_lat !== 33) begin errors++; $display("FAIL post_reset_mult: got %h lat %0d expected 000000000000000c lat 33", {obs_hi, obs_lo}, obs_lat); end
    exp_hi = 32'd0; exp_lo = 32'd12;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] e1, e2;
    int lat, gap;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = ref_mul(a1, b1); e2 = ref_mul(a2, b2);
    @(negedge clk); MultOp = 1'b1; A = a1; B = b1;
    @(negedge clk); MultOp = 1'b0;
    lat = 0;
    while (!Done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 32) begin MultOp = 1'b1; A = a2; B = b2; end
    end
    checks++; if (lat !== 33 || {ResultHI, ResultLO} !== e1) begin errors++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 33", {ResultHI, ResultLO}, lat, e1); end
    @(negedge clk); MultOp = 1'b0;
    gap = 1;
    while (!Done && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    checks++; if (gap !== 34) begin errors++; $display("FAIL b2b_gap: got %0d expected 34", gap); end
    checks++; if ({ResultHI, ResultLO} !== e2) begin errors++; $display("FAIL b2b_second: got %h expected %h", {ResultHI, ResultLO}, e2); end
    {exp_hi, exp_lo} = e2;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] e;
    logic        is_div;
    int          want_lat;
    logic        want_dz;
    for (int i = 0; i < 40; i++) begin
      a = pick(); b = pick(); is_div = $urandom_range(0, 1) == 1;
      e = is_div ? ref_div(a, b) : ref_mul(a, b);
      want_lat = 33; want_dz = 1'b0;
`ifdef MULT_DIV_ZERO_TRAP_EN
      if (is_div && b == 32'd0) begin
        e = {exp_hi, exp_lo}; want_lat = 1; want_dz = 1'b1;
      end
`endif
      do_op(!is_div, is_div, a, b);
      checks++;
      if ({obs_hi, obs_lo} !== e || obs_lat !== want_lat || obs_dz !== want_dz) begin
        errors++;
        $display("FAIL random_%0s a=%h b=%h: got %h lat %0d dz %b expected %h lat %0d dz %b",
                 is_div ? "div" : "mul", a, b, {obs_hi, obs_lo}, obs_lat, obs_dz, e, want_lat, want_dz);
      end
      {exp_hi, exp_lo} = e;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
